// File: rtl/fp32_pkg.sv
// Shared IEEE-754 single-precision constants, operand classes and divider
// controller states.
package fp32_pkg;

  localparam int          EXP_W   = 8;
  localparam int          MAN_W   = 23;
  localparam int          BIAS    = 127;
  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF = 32'h7F80_0000;

  typedef enum logic [1:0] {
    CLS_ZERO   = 2'd0,
    CLS_FINITE = 2'd1,
    CLS_INF    = 2'd2,
    CLS_NAN    = 2'd3
  } op_class_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_UNPACK = 3'd1,
    ST_DIVIDE = 3'd2,
    ST_ROUND  = 3'd3,
    ST_DONE   = 3'd4
  } div_state_e;

  // Denormals carry a zero exponent and are deliberately folded into ZERO.
  function automatic op_class_e classify(input logic [31:0] x);
    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] f;
    e = x[30:23];
    f = x[22:0];
    if (e == '0)                 return CLS_ZERO;
    else if (e == '1 && f != '0) return CLS_NAN;
    else if (e == '1)            return CLS_INF;
    else                         return CLS_FINITE;
  endfunction

endpackage

// File: rtl/fp32_div_step.sv
// One restoring-division iteration: conditional subtract of the divisor,
// then shift the partial remainder left by one.
module fp32_div_step
  import fp32_pkg::*;
(
  input  logic [24:0] rem_i,
  input  logic [23:0] div_i,
  output logic        q_bit,
  output logic [24:0] rem_o
);

  logic [24:0] diff;
  logic [24:0] kept;

  always_comb begin
    diff  = rem_i - {1'b0, div_i};
    q_bit = (rem_i >= {1'b0, div_i});
    kept  = q_bit ? diff : rem_i;
    // After a restoring step kept < divisor < 2^24, so the MSB is always free.
    rem_o = {kept[23:0], 1'b0};
  end

endmodule

// File: rtl/fp32_div_seq.sv
// Sequential IEEE-754 single-precision divider: handshake in, one quotient
// bit per cycle, round-to-nearest-even, result held until consumed.
module fp32_div_seq
  import fp32_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in1,
  input  logic [DATA_WIDTH-1:0] in2,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out,
  output logic                  div_by_zero,
  output logic                  invalid
);

  div_state_e  state_q, state_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [24:0] rem_q, rem_d;
  logic [25:0] quo_q, quo_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] out_q, out_d;
  logic        dbz_q, dbz_d;
  logic        inv_q, inv_d;

  logic        step_q_bit;
  logic [24:0] step_rem;

  op_class_e   cls_a, cls_b;
  logic        sign;

  logic               q_hi;
  logic [22:0]        frac_pre;
  logic               guard, sticky, inc;
  logic [23:0]        frac_rnd;
  logic signed [9:0]  exp_pre, exp_fin;
  logic [31:0]        rnd_result;

  fp32_div_step u_step (
    .rem_i (rem_q),
    .div_i ({1'b1, b_q[22:0]}),
    .q_bit (step_q_bit),
    .rem_o (step_rem)
  );

  assign cls_a = classify(a_q);
  assign cls_b = classify(b_q);
  assign sign  = a_q[31] ^ b_q[31];

  // Rounding works on the 23-bit fraction: a carry out of it is exactly the
  // mantissa overflow to 2.0, which leaves the fraction zero and bumps E.
  always_comb begin
    q_hi     = quo_q[25];
    frac_pre = q_hi ? quo_q[24:2] : quo_q[23:1];
    guard    = q_hi ? quo_q[1] : quo_q[0];
    sticky   = (q_hi & quo_q[0]) | (rem_q != '0);
    inc      = guard & (sticky | frac_pre[0]);
    frac_rnd = {1'b0, frac_pre} + {23'd0, inc};
    exp_pre  = 10'(a_q[30:23]) - 10'(b_q[30:23])
             + (q_hi ? 10'(BIAS) : 10'(BIAS - 1));
    exp_fin  = exp_pre + 10'(frac_rnd[23]);
    if (exp_fin >= 10'sd255)    rnd_result = {sign, POS_INF[30:0]};
    else if (exp_fin <= 10'sd0) rnd_result = {sign, 31'd0};
    else                        rnd_result = {sign, exp_fin[7:0], frac_rnd[22:0]};
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    dbz_d   = dbz_q;
    inv_d   = inv_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = in1;
          b_d     = in2;
          state_d = ST_UNPACK;
        end
      end
      ST_UNPACK: begin
        rem_d   = {2'b01, a_q[22:0]};
        quo_d   = '0;
        cnt_d   = 5'd25;
        dbz_d   = 1'b0;
        inv_d   = 1'b0;
        state_d = ST_DONE;
        if (cls_a == CLS_NAN || cls_b == CLS_NAN ||
            (cls_a == CLS_ZERO && cls_b == CLS_ZERO) ||
            (cls_a == CLS_INF && cls_b == CLS_INF)) begin
          out_d = QNAN;
          inv_d = 1'b1;
        end else if (cls_a == CLS_FINITE && cls_b == CLS_ZERO) begin
          out_d = {sign, POS_INF[30:0]};
          dbz_d = 1'b1;
        end else if (cls_a == CLS_INF) begin
          out_d = {sign, POS_INF[30:0]};
        end else if (cls_a == CLS_ZERO || cls_b == CLS_INF) begin
          out_d = {sign, 31'd0};
        end else begin
          state_d = ST_DIVIDE;
        end
      end
      ST_DIVIDE: begin
        rem_d = step_rem;
        quo_d = {quo_q[24:0], step_q_bit};
        if (cnt_q == '0) state_d = ST_ROUND;
        else             cnt_d   = cnt_q - 5'd1;
      end
      ST_ROUND: begin
        out_d   = rnd_result;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      dbz_q   <= 1'b0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      dbz_q   <= dbz_d;
      inv_q   <= inv_d;
    end
  end

  assign in_ready    = (state_q == ST_IDLE) && !rst;
  assign out_valid   = (state_q == ST_DONE);
  assign out         = out_q;
  assign div_by_zero = dbz_q;
  assign invalid     = inv_q;

endmodule

// File: tb/tb_fp32_div_seq.sv
// Scoreboard bench for fp32_div_seq: directed vectors push expectations,
// an independent monitor pops and checks each presented result.
module tb_fp32_div_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in1 = '0;
  logic [31:0] in2 = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out;
  logic        div_by_zero;
  logic        invalid;

  int errs = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    string       name;
    logic [31:0] res;
    logic        dbz;
    logic        inv;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];

  fp32_div_seq #(.DATA_WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in1         (in1),
    .in2         (in2),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out         (out),
    .div_by_zero (div_by_zero),
    .invalid     (invalid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: first cycle a result is presented it is compared with the
  // scoreboard head; while it is held, it must not change.
  initial begin
    logic active;
    exp_t cur;
    active = 1'b0;
    forever begin
      @(negedge clk);
      if (rst || !out_valid) begin
        active = 1'b0;
      end else if (!active) begin
        active = 1'b1;
        if (sb.size() == 0) begin
          checks++;
          errs++;
          $display("FAIL unexpected_output: got %h expected no result", out);
          cur.name = "unexpected";
          cur.res  = out;
          cur.dbz  = div_by_zero;
          cur.inv  = invalid;
        end else begin
          cur = sb.pop_front();
          chk({cur.name, " out"},     out,              cur.res);
          chk({cur.name, " dbz"},     32'(div_by_zero), 32'(cur.dbz));
          chk({cur.name, " invalid"}, 32'(invalid),     32'(cur.inv));
          chk({cur.name, " latency"}, 32'(cyc - cur.acc), 32'(cur.lat));
        end
      end else begin
        chk({cur.name, " hold out"},      out,              cur.res);
        chk({cur.name, " hold dbz"},      32'(div_by_zero), 32'(cur.dbz));
        chk({cur.name, " hold invalid"},  32'(invalid),     32'(cur.inv));
        chk({cur.name, " hold in_ready"}, 32'(in_ready),    32'd0);
      end
    end
  end

  task automatic send(input string name, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] res, input logic dbz, input logic inv,
                      input int lat, input bit push);
    int n;
    @(negedge clk);
    in_valid = 1'b1;
    in1 = a;
    in2 = b;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errs++;
      $display("FAIL %s accept_timeout: got in_ready=0 expected 1", name);
      in_valid = 1'b0;
    end else begin
      if (push) sb.push_back('{name, res, dbz, inv, lat, cyc + 1});
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in1 = $urandom;
      in2 = $urandom;
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((sb.size() != 0 || out_valid) && n < 100);
    if (sb.size() != 0 || out_valid) begin
      checks++;
      errs++;
      $display("FAIL %s drain_timeout: got pending=%0d expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic run(input string name, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] res, input logic dbz, input logic inv, input int lat);
    send(name, a, b, res, dbz, inv, lat, 1'b1);
    drain(name);
  endtask

  initial begin
    bit saw_valid;
    int n;

    repeat (3) @(negedge clk);
    chk("reset in_ready",  32'(in_ready),    32'd0);
    chk("reset out_valid", 32'(out_valid),   32'd0);
    chk("reset out",       out,              32'd0);
    chk("reset dbz",       32'(div_by_zero), 32'd0);
    chk("reset invalid",   32'(invalid),     32'd0);
    rst = 1'b0;
    #1;
    chk("post_reset in_ready", 32'(in_ready), 32'd1);

    run("6/2",        32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0, 28);
    run("-6/2",       32'hC0C00000, 32'h40000000, 32'hC0400000, 1'b0, 1'b0, 28);
    run("1/3",        32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 1'b0, 1'b0, 28);
    run("5/0",        32'h40A00000, 32'h00000000, 32'h7F800000, 1'b1, 1'b0, 1);
    run("0/0",        32'h00000000, 32'h00000000, 32'h7FC00000, 1'b0, 1'b1, 1);
    run("inf/inf",    32'h7F800000, 32'h7F800000, 32'h7FC00000, 1'b0, 1'b1, 1);
    run("nan/1",      32'h7FC00001, 32'h3F800000, 32'h7FC00000, 1'b0, 1'b1, 1);
    run("-inf/2",     32'hFF800000, 32'h40000000, 32'hFF800000, 1'b0, 1'b0, 1);
    run("-0/1",       32'h80000000, 32'h3F800000, 32'h80000000, 1'b0, 1'b0, 1);
    run("1/-inf",     32'h3F800000, 32'hFF800000, 32'h80000000, 1'b0, 1'b0, 1);
    run("overflow",   32'h7F7FFFFF, 32'h3F000000, 32'h7F800000, 1'b0, 1'b0, 28);
    run("flush",      32'h00800000, 32'h40000000, 32'h00000000, 1'b0, 1'b0, 28);
    run("denormal",   32'h00400000, 32'h3F800000, 32'h00000000, 1'b0, 1'b0, 1);

    // Back-pressure: result and flags held for 10 cycles, in_valid pulses ignored.
    out_ready = 1'b0;
    send("hold 5/0", 32'h40A00000, 32'h00000000, 32'h7F800000, 1'b1, 1'b0, 1, 1'b1);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = (i % 2 == 0);
      in1 = 32'h40C00000;
      in2 = 32'h40000000;
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain("hold");

    // Reset mid-DIVIDE abandons the operation.
    send("abandoned", 32'h40C00000, 32'h40000000, 32'h0, 1'b0, 1'b0, 0, 1'b0);
    repeat (12) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("after_rst in_ready",  32'(in_ready),  32'd1);
    chk("after_rst out_valid", 32'(out_valid), 32'd0);
    saw_valid = 1'b0;
    repeat (35) begin
      @(negedge clk);
      if (out_valid) saw_valid = 1'b1;
    end
    chk("abandoned no_output", 32'(saw_valid), 32'd0);

    run("6/2 after rst", 32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0, 28);

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
